// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, memory-op codes and memory-stage state type
package cpu_pkg;

    localparam int GPR_IDX_W = 5;
    localparam int WORD_W    = 32;

    localparam logic [2:0] MEM_OP_NONE  = 3'd0;
    localparam logic [2:0] MEM_OP_LB    = 3'd1;
    localparam logic [2:0] MEM_OP_LBU   = 3'd2;
    localparam logic [2:0] MEM_OP_LH    = 3'd3;
    localparam logic [2:0] MEM_OP_LHU   = 3'd4;
    localparam logic [2:0] MEM_OP_LW    = 3'd5;
    localparam logic [2:0] MEM_OP_STORE = 3'd6;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-RAM request/response bus between memory stage and RAM
interface memory_stage_if;
    import cpu_pkg::*;

    logic              dram_en;
    logic [3:0]        dram_wen;
    logic [WORD_W-1:0] dram_addr;
    logic [WORD_W-1:0] dram_wdata;
    logic [WORD_W-1:0] dram_rdata;
    logic              dram_ack;

    modport master (
        output dram_en,
        output dram_wen,
        output dram_addr,
        output dram_wdata,
        input  dram_rdata,
        input  dram_ack
    );

    modport slave (
        input  dram_en,
        input  dram_wen,
        input  dram_addr,
        input  dram_wdata,
        output dram_rdata,
        output dram_ack
    );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and sign/zero-extends the load lane from a RAM word
module load_align
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        mem_op,
    output logic [WORD_W-1:0] data
);

    logic [WORD_W-1:0] shifted;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;

    // Pick the addressed byte/halfword lane and extend it according to the op
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        byte_lane = shifted[7:0];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        data      = rdata;
        case (mem_op)
            MEM_OP_LB:  data = {{24{byte_lane[7]}}, byte_lane};
            MEM_OP_LBU: data = {24'd0, byte_lane};
            MEM_OP_LH:  data = {{16{half_lane[15]}}, half_lane};
            MEM_OP_LHU: data = {16'd0, half_lane};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline memory stage: data-RAM access, load alignment, writeback values
module memory_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 exe_valid,
    output logic                 mem_allowin,
    input  logic                 exe_wen,
    input  logic [GPR_IDX_W-1:0] exe_regsrc,
    input  logic [WORD_W-1:0]    exe_alu_result,
    input  logic [2:0]           exe_mem_op,
    input  logic [1:0]           exe_store_size,
    input  logic [WORD_W-1:0]    exe_store_data,
    memory_stage_if.master       dram,
    output logic                 mem_valid,
    output logic                 mem_wen,
    output logic [GPR_IDX_W-1:0] mem_regsrc,
    output logic [WORD_W-1:0]    mem_wdata,
    output logic                 mem_addr_err,
    output logic                 mem_timeout
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 1);

    mem_state_t           state;
    logic [2:0]           op_r;
    logic [1:0]           off_r;
    logic                 wen_r;
    logic [GPR_IDX_W-1:0] regsrc_r;
    logic [WORD_W-1:0]    wdata_r;
    logic                 err_r;
    logic                 timeout_r;
    logic [3:0]           dwen_r;
    logic [WORD_W-1:0]    daddr_r;
    logic [WORD_W-1:0]    dwdata_r;
    logic [31:0]          wait_cnt;

    logic                 accept;
    logic                 is_access;
    logic                 is_store;
    logic                 misaligned;
    logic [3:0]           st_wen;
    logic [WORD_W-1:0]    st_data;
    logic [WORD_W-1:0]    load_data;

    assign mem_allowin   = (state != ACCESS);
    assign accept        = exe_valid && mem_allowin;
    assign mem_valid     = (state == DONE);
    assign mem_wen       = mem_valid && wen_r;
    assign mem_regsrc    = regsrc_r;
    assign mem_wdata     = wdata_r;
    assign mem_addr_err  = err_r;
    assign mem_timeout   = timeout_r;
    assign dram.dram_en    = (state == ACCESS);
    assign dram.dram_wen   = dram.dram_en ? dwen_r : 4'b0000;
    assign dram.dram_addr  = daddr_r;
    assign dram.dram_wdata = dwdata_r;

    load_align u_load_align (
        .rdata  (dram.dram_rdata),
        .offset (off_r),
        .mem_op (op_r),
        .data   (load_data)
    );

    // Decode the incoming instruction: access type, alignment check, store lanes
    always_comb begin
        is_store   = (exe_mem_op == MEM_OP_STORE);
        is_access  = (exe_mem_op != MEM_OP_NONE) && (exe_mem_op <= MEM_OP_STORE);
        misaligned = 1'b0;
        st_wen     = 4'b0000;
        st_data    = exe_store_data;
        case (exe_mem_op)
            MEM_OP_LH, MEM_OP_LHU: misaligned = exe_alu_result[0];
            MEM_OP_LW:             misaligned = (exe_alu_result[1:0] != 2'b00);
            MEM_OP_STORE: begin
                case (exe_store_size)
                    SIZE_BYTE: begin
                        st_wen  = 4'b0001 << exe_alu_result[1:0];
                        st_data = {4{exe_store_data[7:0]}};
                    end
                    SIZE_HALF: begin
                        misaligned = exe_alu_result[0];
                        st_wen     = exe_alu_result[1] ? 4'b1100 : 4'b0011;
                        st_data    = {2{exe_store_data[15:0]}};
                    end
                    default: begin
                        misaligned = (exe_alu_result[1:0] != 2'b00);
                        st_wen     = 4'b1111;
                    end
                endcase
            end
            default: misaligned = 1'b0;
        endcase
    end

    // Stage state machine: accept, wait for RAM ack, present result for one cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            op_r      <= MEM_OP_NONE;
            off_r     <= 2'b00;
            wen_r     <= 1'b0;
            regsrc_r  <= '0;
            wdata_r   <= '0;
            err_r     <= 1'b0;
            timeout_r <= 1'b0;
            dwen_r    <= 4'b0000;
            daddr_r   <= '0;
            dwdata_r  <= '0;
            wait_cnt  <= 32'd0;
        end else if (accept) begin
            op_r     <= exe_mem_op;
            off_r    <= exe_alu_result[1:0];
            regsrc_r <= exe_regsrc;
            wdata_r  <= exe_alu_result;
            err_r    <= misaligned;
            wen_r    <= exe_wen && !is_store && !misaligned;
            daddr_r  <= {exe_alu_result[31:2], 2'b00};
            dwen_r   <= st_wen;
            dwdata_r <= st_data;
            wait_cnt <= 32'd0;
            state    <= (is_access && !misaligned) ? ACCESS : DONE;
        end else begin
            case (state)
                ACCESS: begin
                    if (dram.dram_ack) begin
                        state <= DONE;
                        if (op_r != MEM_OP_STORE) begin
                            wdata_r <= load_data;
                        end
                    end else if ((ACK_TIMEOUT != 0) && !timeout_r) begin
                        if (wait_cnt == TIMEOUT_LAST) begin
                            timeout_r <= 1'b1;
                        end
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    err_r <= 1'b0;
                    wen_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
